// File: rtl/cache_bus_arbiter.sv
// rtl/cache_bus_arbiter.sv - I/D cache refill arbiter onto a single burst memory bus
module cache_bus_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    // I-cache read port
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic [7:0]  i_len,
    output logic        i_addr_ok,
    output logic [31:0] i_rdata,
    output logic        i_rvalid,
    output logic        i_rlast,
    // D-cache read/write port
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [7:0]  d_len,
    output logic        d_addr_ok,
    output logic [31:0] d_rdata,
    output logic        d_rvalid,
    output logic        d_rlast,
    input  logic [31:0] d_wdata,
    output logic        d_wready,
    output logic        d_bvalid,
    // downstream bus
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [7:0]  bus_len,
    input  logic        bus_addr_ok,
    input  logic [31:0] bus_rdata,
    input  logic        bus_rvalid,
    input  logic        bus_rlast,
    output logic [31:0] bus_wdata,
    output logic        bus_wvalid,
    output logic        bus_wlast,
    input  logic        bus_wready,
    input  logic        bus_bvalid
);

    localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        RDATA = 3'd2,
        WDATA = 3'd3,
        WRESP = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic        gnt_d;        // 1: D-cache owns the bus, 0: I-cache
    logic        reg_we;
    logic [31:0] reg_addr;
    logic [7:0]  reg_len;
    logic [7:0]  beat_cnt;
    logic [2:0]  starve_cnt;

    logic        grant_d;
    logic        grant_i;
    logic        w_fire;
    logic        w_last;

    // D wins unless the I side has been passed over STARVE_LIMIT times in a row
    assign grant_d = d_req && (!i_req || (starve_cnt < STARVE_MAX));
    assign grant_i = !grant_d && i_req;

    assign w_fire  = (state == WDATA) && bus_wready;
    assign w_last  = (beat_cnt == reg_len);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and phase-dependent outputs
    always_comb begin
        state_nxt  = state;
        bus_req    = 1'b0;
        i_addr_ok  = 1'b0;
        d_addr_ok  = 1'b0;
        i_rdata    = 32'd0;
        i_rvalid   = 1'b0;
        i_rlast    = 1'b0;
        d_rdata    = 32'd0;
        d_rvalid   = 1'b0;
        d_rlast    = 1'b0;
        bus_wdata  = 32'd0;
        bus_wvalid = 1'b0;
        bus_wlast  = 1'b0;
        d_wready   = 1'b0;
        d_bvalid   = 1'b0;
        case (state)
            IDLE: begin
                if (grant_d || grant_i) begin
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                bus_req = 1'b1;
                if (bus_addr_ok) begin
                    i_addr_ok = !gnt_d;
                    d_addr_ok = gnt_d;
                    state_nxt = reg_we ? WDATA : RDATA;
                end
            end
            RDATA: begin
                if (gnt_d) begin
                    d_rdata  = bus_rdata;
                    d_rvalid = bus_rvalid;
                    d_rlast  = bus_rlast;
                end else begin
                    i_rdata  = bus_rdata;
                    i_rvalid = bus_rvalid;
                    i_rlast  = bus_rlast;
                end
                if (bus_rvalid && bus_rlast) begin
                    state_nxt = IDLE;
                end
            end
            WDATA: begin
                bus_wvalid = 1'b1;
                bus_wdata  = d_wdata;
                bus_wlast  = w_last;
                d_wready   = bus_wready;
                if (w_fire && w_last) begin
                    state_nxt = WRESP;
                end
            end
            WRESP: begin
                d_bvalid = bus_bvalid;
                if (bus_bvalid) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Latch the granted request; fields are frozen until the next IDLE grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_d    <= 1'b0;
            reg_we   <= 1'b0;
            reg_addr <= 32'd0;
            reg_len  <= 8'd0;
        end else if (state == IDLE) begin
            if (grant_d) begin
                gnt_d    <= 1'b1;
                reg_we   <= d_we;
                reg_addr <= d_addr;
                reg_len  <= d_len;
            end else if (grant_i) begin
                gnt_d    <= 1'b0;
                reg_we   <= 1'b0;
                reg_addr <= i_addr;
                reg_len  <= i_len;
            end
        end
    end

    // Write beat counter; holds on the last beat so len=255 never wraps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= 8'd0;
        end else if (state == IDLE) begin
            beat_cnt <= 8'd0;
        end else if (w_fire && !w_last) begin
            beat_cnt <= beat_cnt + 8'd1;
        end
    end

    // Count D grants that bypassed a waiting I request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= 3'd0;
        end else if (state == IDLE) begin
            if (!i_req || grant_i) begin
                starve_cnt <= 3'd0;
            end else if (grant_d && (starve_cnt != 3'd7)) begin
                starve_cnt <= starve_cnt + 3'd1;
            end
        end
    end

    assign bus_we   = reg_we;
    assign bus_addr = reg_addr;
    assign bus_len  = reg_len;

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// tb/tb_cache_bus_arbiter.sv - directed self-checking bench for cache_bus_arbiter
module tb_cache_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [7:0]  i_len;
    logic        i_addr_ok;
    logic [31:0] i_rdata;
    logic        i_rvalid;
    logic        i_rlast;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [7:0]  d_len;
    logic        d_addr_ok;
    logic [31:0] d_rdata;
    logic        d_rvalid;
    logic        d_rlast;
    logic [31:0] d_wdata;
    logic        d_wready;
    logic        d_bvalid;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [7:0]  bus_len;
    logic        bus_addr_ok;
    logic [31:0] bus_rdata;
    logic        bus_rvalid;
    logic        bus_rlast;
    logic [31:0] bus_wdata;
    logic        bus_wvalid;
    logic        bus_wlast;
    logic        bus_wready;
    logic        bus_bvalid;

    int checks = 0;
    int errors = 0;

    cache_bus_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_len(i_len), .i_addr_ok(i_addr_ok),
        .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_rlast(i_rlast),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_len(d_len), .d_addr_ok(d_addr_ok),
        .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_rlast(d_rlast),
        .d_wdata(d_wdata), .d_wready(d_wready), .d_bvalid(d_bvalid),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_len(bus_len),
        .bus_addr_ok(bus_addr_ok), .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
        .bus_rlast(bus_rlast), .bus_wdata(bus_wdata), .bus_wvalid(bus_wvalid),
        .bus_wlast(bus_wlast), .bus_wready(bus_wready), .bus_bvalid(bus_bvalid)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation ran past time limit");
        $fatal(1, "timeout");
    end

    // advance to just after the next rising edge; inputs change here, checks follow after #1
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_req = 0; i_addr = 0; i_len = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_len = 0; d_wdata = 0;
        bus_addr_ok = 0; bus_rdata = 0; bus_rvalid = 0; bus_rlast = 0;
        bus_wready = 0; bus_bvalid = 0;
        cyc(); cyc();
        #1;
        checks++;
        if ({bus_req, bus_wvalid, bus_wlast, i_addr_ok, d_addr_ok, i_rvalid, i_rlast,
             d_rvalid, d_rlast, d_wready, d_bvalid} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0", {bus_req, bus_wvalid, bus_wlast,
                     i_addr_ok, d_addr_ok, i_rvalid, i_rlast, d_rvalid, d_rlast, d_wready, d_bvalid});
        end
        checks++;
        if (bus_addr !== 32'd0 || bus_len !== 8'd0 || bus_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_fields: addr %h len %0d we %b expected 0", bus_addr, bus_len, bus_we);
        end
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_single_i_read();
        i_req = 1; i_addr = 32'h1FC0_0000; i_len = 8'd3;
        #1;
        checks++;
        if (bus_req !== 1'b0) begin
            errors++; $display("FAIL iread_no_early_req: got %b expected 0", bus_req);
        end
        cyc();
        bus_addr_ok = 1;
        #1;
        checks++;
        if (bus_req !== 1'b1 || bus_addr !== 32'h1FC0_0000 || bus_len !== 8'd3 || bus_we !== 1'b0) begin
            errors++;
            $display("FAIL iread_bus_req: req %b addr %h len %0d we %b expected 1 1fc00000 3 0",
                     bus_req, bus_addr, bus_len, bus_we);
        end
        checks++;
        if (i_addr_ok !== 1'b1 || d_addr_ok !== 1'b0) begin
            errors++; $display("FAIL iread_addr_ok: i %b d %b expected 1 0", i_addr_ok, d_addr_ok);
        end
        cyc();
        i_req = 0; bus_addr_ok = 0;
        for (int k = 0; k < 4; k++) begin
            bus_rvalid = 1; bus_rdata = 32'h100 + k; bus_rlast = (k == 3);
            #1;
            checks++;
            if (i_rvalid !== 1'b1 || i_rdata !== 32'h100 + k || i_rlast !== (k == 3) || d_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL iread_beat%0d: rvalid %b data %h rlast %b d_rvalid %b expected 1 %h %b 0",
                         k, i_rvalid, i_rdata, i_rlast, d_rvalid, 32'h100 + k, (k == 3));
            end
            cyc();
        end
        bus_rvalid = 0; bus_rlast = 0;
        #1;
        checks++;
        if (bus_req !== 1'b0 || i_rvalid !== 1'b0) begin
            errors++; $display("FAIL iread_back_idle: req %b rvalid %b expected 0 0", bus_req, i_rvalid);
        end
        cyc();
    endtask

    task automatic test_priority();
        i_req = 1; i_addr = 32'h0000_4000; i_len = 8'd1;
        d_req = 1; d_we = 0; d_addr = 32'h8000_1000; d_len = 8'd7;
        cyc();
        bus_addr_ok = 1;
        #1;
        checks++;
        if (bus_addr !== 32'h8000_1000 || bus_len !== 8'd7 || d_addr_ok !== 1'b1 || i_addr_ok !== 1'b0) begin
            errors++;
            $display("FAIL prio_d_first: addr %h len %0d d_ok %b i_ok %b expected 80001000 7 1 0",
                     bus_addr, bus_len, d_addr_ok, i_addr_ok);
        end
        cyc();
        d_req = 0; bus_addr_ok = 0;
        for (int k = 0; k < 8; k++) begin
            bus_rvalid = 1; bus_rdata = 32'hD000 + k; bus_rlast = (k == 7);
            #1;
            checks++;
            if (d_rvalid !== 1'b1 || d_rdata !== 32'hD000 + k || d_rlast !== (k == 7) || i_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL prio_d_beat%0d: rvalid %b data %h rlast %b i_rvalid %b expected 1 %h %b 0",
                         k, d_rvalid, d_rdata, d_rlast, i_rvalid, 32'hD000 + k, (k == 7));
            end
            cyc();
        end
        bus_rvalid = 0; bus_rlast = 0;
        #1;
        checks++;
        if (bus_req !== 1'b0) begin
            errors++; $display("FAIL prio_idle_gap: bus_req %b expected 0", bus_req);
        end
        cyc();
        bus_addr_ok = 1;
        #1;
        checks++;
        if (bus_req !== 1'b1 || bus_addr !== 32'h0000_4000 || i_addr_ok !== 1'b1) begin
            errors++;
            $display("FAIL prio_i_second: req %b addr %h i_ok %b expected 1 00004000 1", bus_req, bus_addr, i_addr_ok);
        end
        cyc();
        i_req = 0; bus_addr_ok = 0;
        for (int k = 0; k < 2; k++) begin
            bus_rvalid = 1; bus_rdata = 32'h1000 + k; bus_rlast = (k == 1);
            #1;
            checks++;
            if (i_rvalid !== 1'b1 || i_rdata !== 32'h1000 + k || i_rlast !== (k == 1) || d_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL prio_i_beat%0d: rvalid %b data %h rlast %b d_rvalid %b", k, i_rvalid, i_rdata, i_rlast, d_rvalid);
            end
            cyc();
        end
        bus_rvalid = 0; bus_rlast = 0;
        cyc();
    endtask

    task automatic test_write();
        int idx = 0;
        int c = 0;
        d_req = 1; d_we = 1; d_addr = 32'h0000_2000; d_len = 8'd3;
        cyc();
        bus_addr_ok = 1;
        #1;
        checks++;
        if (bus_req !== 1'b1 || bus_we !== 1'b1 || d_addr_ok !== 1'b1) begin
            errors++; $display("FAIL wr_addr: req %b we %b d_ok %b expected 1 1 1", bus_req, bus_we, d_addr_ok);
        end
        cyc();
        d_req = 0; d_we = 0; bus_addr_ok = 0;
        while (idx < 4 && c < 20) begin
            d_wdata = 32'hA0 + idx;
            bus_wready = (c % 2 == 1);
            #1;
            checks++;
            if (bus_wvalid !== 1'b1 || bus_wdata !== 32'hA0 + idx || bus_wlast !== (idx == 3) || d_wready !== bus_wready) begin
                errors++;
                $display("FAIL wr_beat%0d_c%0d: wvalid %b wdata %h wlast %b wready %b expected 1 %h %b %b",
                         idx, c, bus_wvalid, bus_wdata, bus_wlast, d_wready, 32'hA0 + idx, (idx == 3), bus_wready);
            end
            if (bus_wready) idx++;
            cyc();
            c++;
        end
        checks++;
        if (idx != 4) begin
            errors++; $display("FAIL wr_beats_done: got %0d expected 4", idx);
        end
        bus_wready = 0;
        #1;
        checks++;
        if (d_bvalid !== 1'b0 || bus_wvalid !== 1'b0) begin
            errors++; $display("FAIL wr_resp_wait: bvalid %b wvalid %b expected 0 0", d_bvalid, bus_wvalid);
        end
        cyc();
        bus_bvalid = 1;
        #1;
        checks++;
        if (d_bvalid !== 1'b1) begin
            errors++; $display("FAIL wr_bvalid: got %b expected 1", d_bvalid);
        end
        cyc();
        bus_bvalid = 0;
        #1;
        checks++;
        if (d_bvalid !== 1'b0 || bus_req !== 1'b0) begin
            errors++; $display("FAIL wr_done_idle: bvalid %b req %b expected 0 0", d_bvalid, bus_req);
        end
        cyc();
    endtask

    task automatic test_long_write();
        int beats = 0;
        int wlast_seen = 0;
        d_req = 1; d_we = 1; d_addr = 32'h0000_3000; d_len = 8'd255;
        cyc();
        bus_addr_ok = 1;
        cyc();
        d_req = 0; d_we = 0; bus_addr_ok = 0; bus_wready = 1;
        while (bus_wvalid === 1'b1 && beats < 300) begin
            if (bus_wlast === 1'b1) begin
                wlast_seen++;
                checks++;
                if (beats != 255) begin
                    errors++; $display("FAIL long_wlast_pos: wlast at beat %0d expected 255", beats);
                end
            end
            beats++;
            cyc();
        end
        bus_wready = 0;
        checks++;
        if (beats != 256 || wlast_seen != 1) begin
            errors++; $display("FAIL long_beats: got %0d beats %0d wlast expected 256 1", beats, wlast_seen);
        end
        bus_bvalid = 1;
        cyc();
        bus_bvalid = 0;
        cyc();
    endtask

    task automatic test_back_to_back();
        logic exp_i;
        i_req = 1; i_addr = 32'h0000_5000; i_len = 8'd0;
        d_req = 1; d_we = 0; d_addr = 32'h0000_6000; d_len = 8'd0;
        for (int g = 0; g < 6; g++) begin
            exp_i = (g == 4);
            cyc();
            bus_addr_ok = 1;
            #1;
            checks++;
            if (i_addr_ok !== exp_i || d_addr_ok !== !exp_i) begin
                errors++;
                $display("FAIL starve_grant%0d: i_ok %b d_ok %b expected %b %b", g, i_addr_ok, d_addr_ok, exp_i, !exp_i);
            end
            cyc();
            bus_addr_ok = 0; bus_rvalid = 1; bus_rlast = 1; bus_rdata = 32'h55;
            #1;
            checks++;
            if (i_rvalid !== exp_i || d_rvalid !== !exp_i || (exp_i ? i_rlast : d_rlast) !== 1'b1) begin
                errors++;
                $display("FAIL starve_len0_beat%0d: i_rv %b d_rv %b expected %b %b", g, i_rvalid, d_rvalid, exp_i, !exp_i);
            end
            cyc();
            bus_rvalid = 0; bus_rlast = 0;
            if (g == 5) begin
                i_req = 0; d_req = 0;
            end
        end
        cyc();
    endtask

    task automatic test_reset_mid();
        i_req = 1; i_addr = 32'h0000_7000; i_len = 8'd7;
        cyc();
        bus_addr_ok = 1;
        cyc();
        i_req = 0; bus_addr_ok = 0;
        bus_rvalid = 1; bus_rdata = 32'h70; bus_rlast = 0;
        cyc();
        bus_rdata = 32'h71;
        rst = 1;
        #1;
        checks++;
        if (i_rvalid !== 1'b0 || i_rdata !== 32'd0 || bus_req !== 1'b0 || bus_addr !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid: rvalid %b rdata %h req %b addr %h expected 0 0 0 0", i_rvalid, i_rdata, bus_req, bus_addr);
        end
        cyc();
        rst = 0; bus_rvalid = 0;
        cyc();
        i_req = 1; i_addr = 32'h0000_7800; i_len = 8'd0;
        cyc();
        bus_addr_ok = 1;
        #1;
        checks++;
        if (bus_req !== 1'b1 || bus_addr !== 32'h0000_7800 || i_addr_ok !== 1'b1) begin
            errors++;
            $display("FAIL rst_regrant: req %b addr %h i_ok %b expected 1 00007800 1", bus_req, bus_addr, i_addr_ok);
        end
        cyc();
        i_req = 0; bus_addr_ok = 0; bus_rvalid = 1; bus_rlast = 1; bus_rdata = 32'h78;
        #1;
        checks++;
        if (i_rvalid !== 1'b1 || i_rlast !== 1'b1 || i_rdata !== 32'h78) begin
            errors++; $display("FAIL rst_regrant_beat: rvalid %b rlast %b data %h expected 1 1 78", i_rvalid, i_rlast, i_rdata);
        end
        cyc();
        bus_rvalid = 0; bus_rlast = 0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_single_i_read();
        test_priority();
        test_write();
        test_long_write();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
